// File: rtl/mpe_pkg.sv
// Shared types and width helpers for the sequential multi-index priority encoder.
// Imported by priority_encoder_core and multi_priority_encoder_seq.
package mpe_pkg;

    typedef enum logic [1:0] {
        MPE_IDLE = 2'd0,
        MPE_SCAN = 2'd1,
        MPE_DONE = 2'd2
    } mpe_state_e;

    // An index into a WIDTH-bit vector; never narrower than one bit.
    function automatic int mpe_idx_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    // A count that can hold 0..num_out inclusive.
    function automatic int mpe_cnt_w(input int num_out);
        return (num_out < 1) ? 1 : $clog2(num_out + 1);
    endfunction

endpackage

// File: rtl/priority_encoder_core.sv
// Combinational single-step priority encoder: finds the highest-priority set bit
// of mask, reports its position and returns mask with that bit cleared.
module priority_encoder_core
    import mpe_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b0,
    parameter int IDX_W     = mpe_idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] mask,
    output logic             found,
    output logic [IDX_W-1:0] pos,
    output logic [WIDTH-1:0] mask_next
);

    logic [WIDTH-1:0] w_onehot;

    // NOTE: every output of this block gets a default before the loops so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        found    = |mask;
        pos      = '0;
        w_onehot = '0;
        if (LSB_FIRST) begin
            // Descending scan: the last hit, i.e. the lowest set bit, wins.
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (mask[i]) begin
                    pos      = IDX_W'(i);
                    w_onehot = WIDTH'(1) << i;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (mask[i]) begin
                    pos      = IDX_W'(i);
                    w_onehot = WIDTH'(1) << i;
                end
            end
        end
        mask_next = mask & ~w_onehot;
    end

endmodule

// File: rtl/multi_priority_encoder_seq.sv
// Sequential multi-index priority encoder: captures req on start, then emits up to
// NUM_OUT set-bit indices one per clock. Define MPE_LSB_FIRST_EN for lowest-bit-first order.
module multi_priority_encoder_seq
    import mpe_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NUM_OUT = 4,
    parameter int IDX_W   = mpe_idx_w(WIDTH),
    localparam int CNT_W  = mpe_cnt_w(NUM_OUT)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [WIDTH-1:0]         req,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         count,
    output logic [NUM_OUT*IDX_W-1:0] idx,
    output logic [NUM_OUT-1:0]       valid
);

`ifdef MPE_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    mpe_state_e r_state;
    mpe_state_e w_state_next;

    logic [WIDTH-1:0]         r_mask;
    logic [CNT_W-1:0]         r_count;
    logic [NUM_OUT*IDX_W-1:0] r_idx;
    logic [NUM_OUT-1:0]       r_valid;
    logic                     r_busy;
    logic                     r_done;

    logic                     w_found;
    logic [IDX_W-1:0]         w_pos;
    logic [WIDTH-1:0]         w_mask_next;
    logic [CNT_W-1:0]         w_count_inc;
    logic                     w_last;

    priority_encoder_core #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST),
        .IDX_W     (IDX_W)
    ) u_core (
        .mask      (r_mask),
        .found     (w_found),
        .pos       (w_pos),
        .mask_next (w_mask_next)
    );

    assign w_count_inc = r_count + 1'b1;
    assign w_last      = (w_count_inc == CNT_W'(NUM_OUT)) || (w_mask_next == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= MPE_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MPE_IDLE: if (start) w_state_next = MPE_SCAN;
            MPE_SCAN: if (!w_found || w_last) w_state_next = MPE_DONE;
            MPE_DONE: w_state_next = MPE_IDLE;
            default:  w_state_next = MPE_IDLE;
        endcase
    end

    // busy/done are registered from the next state so they align with r_state
    // without any combinational path from start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mask  <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_valid <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= (w_state_next != MPE_IDLE);
            r_done <= (w_state_next == MPE_DONE);
            case (r_state)
                MPE_IDLE: begin
                    if (start) begin
                        r_mask  <= req;
                        r_count <= '0;
                        r_idx   <= '0;
                        r_valid <= '0;
                    end
                end
                MPE_SCAN: begin
                    if (w_found) begin
                        r_mask  <= w_mask_next;
                        r_count <= w_count_inc;
                        for (int i = 0; i < NUM_OUT; i++) begin
                            if (i == int'(r_count)) begin
                                r_idx[i*IDX_W +: IDX_W] <= w_pos;
                                r_valid[i]              <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign count = r_count;
    assign idx   = r_idx;
    assign valid = r_valid;

endmodule

// File: tb/tb_multi_priority_encoder_seq.sv
// Directed bench for multi_priority_encoder_seq: NUM_OUT=4 and NUM_OUT=2 instances,
// expected results queued at start and compared when done is observed.
module tb_multi_priority_encoder_seq;

`ifdef MPE_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start1, start2;
    logic [15:0] req1, req2;

    logic        busy1, done1;
    logic [2:0]  count1;
    logic [15:0] idx1;
    logic [3:0]  valid1;

    logic        busy2, done2;
    logic [1:0]  count2;
    logic [7:0]  idx2;
    logic [1:0]  valid2;

    multi_priority_encoder_seq #(.WIDTH(16), .NUM_OUT(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .start(start1), .req(req1),
        .busy(busy1), .done(done1), .count(count1), .idx(idx1), .valid(valid1)
    );

    multi_priority_encoder_seq #(.WIDTH(16), .NUM_OUT(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .req(req2),
        .busy(busy2), .done(done2), .count(count2), .idx(idx2), .valid(valid2)
    );

    typedef struct {
        int          lat;
        int          k;
        logic [63:0] idx;
        logic [63:0] valid;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   sel    = 0;

    logic [63:0] o_busy, o_done, o_count, o_idx, o_valid;

    always_comb begin
        o_busy  = (sel != 0) ? 64'(busy2)  : 64'(busy1);
        o_done  = (sel != 0) ? 64'(done2)  : 64'(done1);
        o_count = (sel != 0) ? 64'(count2) : 64'(count1);
        o_idx   = (sel != 0) ? 64'(idx2)   : 64'(idx1);
        o_valid = (sel != 0) ? 64'(valid2) : 64'(valid1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] r, input int n);
        exp_t e;
        int   k = 0;
        e.idx   = '0;
        e.valid = '0;
        for (int j = 0; j < 16; j++) begin
            int b = LSB ? j : 15 - j;
            if (r[b] && k < n) begin
                e.idx      |= 64'(b) << (4 * k);
                e.valid[k]  = 1'b1;
                k++;
            end
        end
        e.k   = k;
        e.lat = (k == 0) ? 1 : k;
        return e;
    endfunction

    task automatic drive(input int s, input logic st, input logic [15:0] r);
        if (s != 0) begin
            start2 = st;
            req2   = r;
        end else begin
            start1 = st;
            req1   = r;
        end
    endtask

    task automatic run_op(input int s, input logic [15:0] r, input bit pulse, input logic [15:0] mreq);
        exp_t e;
        bit   seen    = 1'b0;
        int   lat_obs = 0;
        sel = s;
        exp_q.push_back(model(r, (s != 0) ? 2 : 4));
        @(negedge clk);
        drive(s, 1'b1, r);
        @(posedge clk);
        @(negedge clk);
        if (pulse) drive(s, 1'b1, mreq);
        else       drive(s, 1'b0, r);
        check("start_busy",  o_busy,  64'd1);
        check("start_done",  o_done,  64'd0);
        check("start_count", o_count, 64'd0);
        check("start_valid", o_valid, 64'd0);
        check("start_idx",   o_idx,   64'd0);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            drive(s, 1'b0, pulse ? mreq : r);
            e = exp_q[0];
            check("count_progress", o_count, 64'((n < e.k) ? n : e.k));
            if (o_done == 64'd1) begin
                seen    = 1'b1;
                lat_obs = n;
                break;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        e = exp_q.pop_front();
        if (seen) begin
            check("done_latency", 64'(lat_obs), 64'(e.lat));
            check("res_count", o_count, 64'(e.k));
            check("res_idx",   o_idx,   e.idx);
            check("res_valid", o_valid, e.valid);
            check("res_busy",  o_busy,  64'd1);
            @(posedge clk);
            @(negedge clk);
            check("after_busy",  o_busy,  64'd0);
            check("after_done",  o_done,  64'd0);
            check("hold_valid",  o_valid, e.valid);
            check("hold_idx",    o_idx,   e.idx);
            @(posedge clk);
            @(negedge clk);
            check("idle_busy",   o_busy,  64'd0);
            check("idle_done",   o_done,  64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [15:0] rnd;
        reset_n = 1'b0;
        start1  = 1'b0;
        start2  = 1'b0;
        req1    = '0;
        req2    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            check("reset_busy",  o_busy,  64'd0);
            check("reset_done",  o_done,  64'd0);
            check("reset_count", o_count, 64'd0);
            check("reset_idx",   o_idx,   64'd0);
            check("reset_valid", o_valid, 64'd0);
        end
        reset_n = 1'b1;

        run_op(0, 16'h8421, 1'b0, 16'h0000);
        run_op(0, 16'h0000, 1'b0, 16'h0000);
        run_op(1, 16'hFFFF, 1'b0, 16'h0000);
        run_op(0, 16'h0005, 1'b1, 16'hF000);
        run_op(1, 16'h0100, 1'b0, 16'h0000);

        // Reset lands on the second edge of a scan: outputs clear and no done appears.
        sel = 0;
        @(negedge clk);
        drive(0, 1'b1, 16'h00FF);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 16'h00FF);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_busy",  o_busy,  64'd0);
        check("abort_done",  o_done,  64'd0);
        check("abort_count", o_count, 64'd0);
        check("abort_idx",   o_idx,   64'd0);
        check("abort_valid", o_valid, 64'd0);
        for (int n = 0; n < 5; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_no_done", o_done, 64'd0);
        end

        run_op(0, 16'h00FF, 1'b0, 16'h0000);
        rnd = 16'($urandom);
        run_op(0, rnd, 1'b0, 16'h0000);
        rnd = 16'($urandom);
        run_op(1, rnd, 1'b0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
